// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//   Bit-serial unsigned subtractor. A single full-subtract cell (two half-subtract
//   stages plus borrow merge) is reused once per clock. Operands are processed
//   LSB-first, and the borrow is carried between cycles in a flop.
//
//   Optional feature: define SERIAL_SUB_ZERO_FLAG_EN to add the o_zero output.
//   o_zero is a registered "result is all zeros" flag.
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_start         request; sampled only while o_ready=1
//   i_a, i_b        minuend / subtrahend, captured on the accept edge
//   i_ack           consumer takes the result; sampled only while o_valid=1
//   o_ready         idle, a request can be accepted
//   o_valid         o_diff/o_borrow hold a completed result
//   o_diff          (i_a - i_b) mod 2^WIDTH
//   o_borrow        1 iff i_a < i_b
//   o_zero          (optional) 1 iff the last result is zero
module serial_subtractor_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ack,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    output logic             o_zero
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    // Holds result bits 0..WIDTH-2. The top bit comes straight from the cell on the last edge.
    logic [WIDTH-2:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // Full-subtract cell: two half-subtract stages plus borrow merge.
    logic             a_k, b_k;
    logic             hd1, hb1, hb2;
    logic             d_k, bout;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        a_k     = a_q[0];
        b_k     = b_q[0];
        hd1     = a_k ^ b_k;
        hb1     = ~a_k & b_k;
        d_k     = hd1 ^ bin_q;
        hb2     = ~hd1 & bin_q;
        bout    = hb1 | hb2;
        shifted = {d_k, res_q};
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        ready_d  = ready_q;
        valid_d  = valid_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = shifted[WIDTH-1:1];
                bin_d = bout;
                if (cnt_q == LAST_BIT) begin
                    // Counter holds at its last value; it is cleared on the next accept.
                    diff_d   = shifted;
                    borrow_d = bout;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    zero_d   = ~|shifted;
`endif
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (i_ack) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_diff   = diff_q;
    assign o_borrow = borrow_q;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign o_zero   = zero_q;
`endif

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
- Bit-serial N-bit unsigned subtractor controller. It reuses a single 1-bit subtract cell once per clock: two half-subtract stages plus borrow merge, forming a full-subtract cell.
- It sequences the operand bits LSB-first, carries the borrow between cycles, and assembles the result.
- A start/ready request side and a valid/ack result side let it sit between a register-file requester and the consumer of the difference.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request to start a subtraction; sampled only when o_ready=1.
- i_a  input  WIDTH  minuend; captured on the accept edge.
- i_b  input  WIDTH  subtrahend; captured on the accept edge.
- i_ack  input  1  consumer accepts the result; meaningful only when o_valid=1.
- o_ready  output  1  controller is idle and can accept i_start.
- o_valid  output  1  o_diff/o_borrow hold a completed result.
- o_diff  output  WIDTH  (i_a - i_b) mod 2^WIDTH.
- o_borrow  output  1  final borrow-out; 1 iff i_a < i_b (unsigned).

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE, o_ready=1, o_valid=0, o_diff=0, o_borrow=0. Shift registers, borrow flop and bit counter are cleared.
- Reset asserted mid-operation aborts immediately. No partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: o_ready=1. On an edge with i_start=1:
  - latch i_a/i_b into shift regs;
  - clear the running borrow and bit counter;
  - go to RUN.
- RUN: o_ready=0, o_valid=0. Each edge processes bit k (k = counter, 0..WIDTH-1):
  - d_k = a_k ^ b_k ^ bin;
  - bout = (~a_k & b_k) | (~(a_k ^ b_k) & bin);
  - d_k shifts into the result register from the MSB side; operand regs shift right; borrow flop <= bout; counter++.
  - On the edge processing k=WIDTH-1, go to DONE and load o_diff (complete) and o_borrow (that bout).
- Latency: o_valid rises exactly WIDTH cycles after the accept edge.
- DONE: o_valid=1, o_ready=0. o_diff/o_borrow are stable. On an edge with i_ack=1: o_valid<=0, go to IDLE. i_ack held low holds DONE indefinitely.
- i_start outside IDLE is ignored, including the cycle where i_ack is high in DONE. A new request is accepted at the earliest one cycle after the ack edge.
- i_ack outside DONE is ignored.
- o_diff/o_borrow are registered. They change only on entry to DONE (or reset) and keep the last result while in IDLE/RUN.
- i_a/i_b changes after the accept edge have no effect on the operation in progress.
- Counter width is clog2(WIDTH). No wrap beyond WIDTH-1 occurs.

Optional Feature:
- Macro: SERIAL_SUB_ZERO_FLAG_EN.
- Defined: adds output port o_zero (1 bit). o_zero is registered and updated together with o_diff: it is 1 iff the result is all zeros. Reset value 0.
- Not defined: port o_zero and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, i_a=8'h5A, i_b=8'h3C, start -> o_valid=1 exactly 8 cycles after accept, o_diff=8'h1E, o_borrow=0; held until i_ack.
- i_a=8'h10, i_b=8'h20 -> o_diff=8'hF0, o_borrow=1. Also i_a=8'h00, i_b=8'h01 -> o_diff=8'hFF, o_borrow=1 (borrow ripples through all bits).
- i_a=i_b=8'hFF -> o_diff=8'h00, o_borrow=0, o_zero=1 with SERIAL_SUB_ZERO_FLAG_EN. Build without the macro: same diff/borrow, port absent.
- Pulse i_start in RUN cycle 3 with different operands, hold i_ack=0 for 5 cycles in DONE, then i_ack=1 with i_start=1 the same cycle:
  - first result is unaffected;
  - o_valid is held through the 5 stall cycles;
  - the start on the ack cycle is ignored;
  - o_ready=1 on the next cycle.
- Drop i_rst_n during RUN cycle 3 -> outputs go to reset values immediately, without waiting for a clock edge. After release, a start with 8'h05-8'h03 -> 8'h02, borrow 0, latency 8.
- Back-to-back random pairs (1000 ops) against a reference model -> every o_diff/o_borrow matches, and every latency is 8.
